// File: rtl/rate_div_pipe.sv
// Single-clock fast-to-slow capture pipeline: a programmable divider tick advances a snapshot through STAGES XOR-rotate stages.
// Optional RATE_DIV_PIPE_PARITY_EN adds out_parity, the registered XOR-reduce of out_data.
module rate_div_stage #(
    parameter int WIDTH = 4
) (
    input  logic             fast_clk,
    input  logic             rst,
    input  logic             adv,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (adv) q <= d ^ {d[0], d[WIDTH-1:1]};
    end
endmodule

module rate_div_pipe #(
    parameter int WIDTH     = 4,
    parameter int MAX_DIV   = 16,
    parameter int STAGES    = 2,
    parameter int RESET_DIV = 4
) (
    input  logic                       fast_clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data,
    input  logic [$clog2(MAX_DIV)-1:0] div_sel,
    input  logic                       div_load,
    input  logic                       flush,
    output logic                       tick,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic                       out_strobe,
    output logic                       div_pend
`ifdef RATE_DIV_PIPE_PARITY_EN
    ,
    output logic                       out_parity
`endif
);
    localparam int DW = $clog2(MAX_DIV);

    logic [DW-1:0]    count, ratio_m1, pend_ratio;
    logic [WIDTH-1:0] in_q, snap;
    logic [WIDTH-1:0] stg [STAGES+1];
    logic [STAGES:0]  vld_pipe;

    // Ratio is held as ratio-1 so MAX_DIV fits in DW bits.
    assign tick = (count == ratio_m1) && !flush;

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            ratio_m1   <= DW'(RESET_DIV - 1);
            pend_ratio <= '0;
            div_pend   <= 1'b0;
        end else begin
            if (flush) begin
                count <= '0;
            end else if (tick) begin
                count <= '0;
                if (div_load)      ratio_m1 <= div_sel;
                else if (div_pend) ratio_m1 <= pend_ratio;
            end else begin
                count <= count + DW'(1);
            end
            // A load coinciding with a tick is consumed directly and never goes pending.
            if (div_load && !tick) begin
                pend_ratio <= div_sel;
                div_pend   <= 1'b1;
            end else if (tick) begin
                div_pend   <= 1'b0;
            end
        end
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            in_q       <= '0;
            snap       <= '0;
            vld_pipe   <= '0;
            out_strobe <= 1'b0;
        end else begin
            in_q       <= data;
            out_strobe <= tick && vld_pipe[STAGES-1];
            if (flush) begin
                vld_pipe <= '0;
            end else if (tick) begin
                snap     <= in_q;
                vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
            end
        end
    end

    assign stg[0] = snap;

    generate
        for (genvar k = 1; k <= STAGES; k++) begin : g_stg
            rate_div_stage #(.WIDTH(WIDTH)) u_stg (
                .fast_clk (fast_clk),
                .rst      (rst),
                .adv      (tick),
                .d        (stg[k-1]),
                .q        (stg[k])
            );
        end
    endgenerate

    assign out_data  = stg[STAGES];
    assign out_valid = vld_pipe[STAGES];

`ifdef RATE_DIV_PIPE_PARITY_EN
    logic [WIDTH-1:0] par_src;
    assign par_src = stg[STAGES-1];

    // Parity of the value the last stage is about to load, so it lands on the same edge.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst)       out_parity <= 1'b0;
        else if (tick) out_parity <= ^(par_src ^ {par_src[0], par_src[WIDTH-1:1]});
    end
`endif
endmodule

// File: tb/tb_rate_div_pipe.sv
// Scoreboard bench for rate_div_pipe: stimulus pushes hand-computed strobe values, a negedge monitor pops and compares.
module tb_rate_div_pipe;
    localparam int W = 4, MD = 16, ST = 2, RD = 4;

    logic                  fast_clk, rst, div_load, flush;
    logic [W-1:0]          data;
    logic [$clog2(MD)-1:0] div_sel;
    logic                  tick, out_valid, out_strobe, div_pend;
    logic [W-1:0]          out_data;
`ifdef RATE_DIV_PIPE_PARITY_EN
    logic                  out_parity;
`endif

    rate_div_pipe #(.WIDTH(W), .MAX_DIV(MD), .STAGES(ST), .RESET_DIV(RD)) dut (
        .fast_clk   (fast_clk),
        .rst        (rst),
        .data       (data),
        .div_sel    (div_sel),
        .div_load   (div_load),
        .flush      (flush),
        .tick       (tick),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_strobe (out_strobe),
        .div_pend   (div_pend)
`ifdef RATE_DIV_PIPE_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    int checks = 0, errors = 0;
    logic [W-1:0] sb [$];
    logic [W-1:0] mon_exp;
    bit t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic edge_t(output bit tk);
        @(negedge fast_clk);
        tk = tick;
        @(posedge fast_clk);
        #1;
    endtask

    // Waits for the next tick edge and checks how many edges it took.
    task automatic tick_chk(input int exp_n, input string nm, input bit push, input logic [W-1:0] v);
        int n;
        bit tk;
        n = 0;
        tk = 1'b0;
        if (push) sb.push_back(v);
        while (!tk && n < 64) begin
            edge_t(tk);
            n++;
        end
        chk(nm, n, exp_n);
    endtask

    always @(negedge fast_clk) begin
        if (!rst && out_strobe) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got out_data %0h expected no strobe", out_data);
            end else begin
                mon_exp = sb.pop_front();
                chk("strobe_out_data", out_data, mon_exp);
                chk("strobe_out_valid", out_valid, 1);
            end
        end
`ifdef RATE_DIV_PIPE_PARITY_EN
        if (!rst) chk("out_parity", out_parity, ^out_data);
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; data = 4'h1; div_sel = '0; div_load = 1'b0; flush = 1'b0;
        repeat (3) @(posedge fast_clk);
        #1;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_strobe", out_strobe, 0);
        chk("rst_div_pend", div_pend, 0);
        chk("rst_tick", tick, 0);
        rst = 1'b0;

        // ratio 4, data 1 -> f(f(1)) = 5
        tick_chk(4, "t1", 0, 0);
        tick_chk(4, "t2", 0, 0);
        chk("t2_out_valid", out_valid, 0);
        tick_chk(4, "t3", 1, 4'h5);
        chk("t3_out_valid", out_valid, 1);
        chk("t3_out_data", out_data, 4'h5);
        chk("t3_out_strobe", out_strobe, 1);
        edge_t(t);
        chk("strobe_pulse", out_strobe, 0);
        tick_chk(3, "t4", 1, 4'h5);
        data = 4'h3;
        tick_chk(4, "t5", 1, 4'h5);
        tick_chk(4, "t6", 1, 4'h5);
        tick_chk(4, "t7", 1, 4'hF);
        data = 4'hF;
        tick_chk(4, "t8", 1, 4'hF);
        tick_chk(4, "t9", 1, 4'hF);
        tick_chk(4, "t10", 1, 4'h0);

        // load ratio 2 at count 1: old period finishes at 4
        edge_t(t);
        div_load = 1'b1; div_sel = 4'd1;
        edge_t(t);
        div_load = 1'b0;
        chk("pend_set", div_pend, 1);
        tick_chk(2, "old_period_end", 1, 4'h0);
        chk("pend_clear", div_pend, 0);
        tick_chk(2, "r2a", 1, 4'h0);
        tick_chk(2, "r2b", 1, 4'h0);

        // ratio 1
        div_load = 1'b1; div_sel = 4'd0;
        edge_t(t);
        div_load = 1'b0;
        chk("pend_r1", div_pend, 1);
        tick_chk(1, "r1_apply", 1, 4'h0);
        tick_chk(1, "r1a", 1, 4'h0);
        tick_chk(1, "r1b", 1, 4'h0);

        // load coincident with tick -> immediate ratio 8
        div_load = 1'b1; div_sel = 4'd7;
        tick_chk(1, "coinc", 1, 4'h0);
        div_load = 1'b0;
        chk("coinc_no_pend", div_pend, 0);
        tick_chk(8, "r8", 1, 4'h0);

        // back-to-back loads, last (5 -> ratio 6) wins
        div_load = 1'b1; div_sel = 4'd2;
        edge_t(t);
        div_sel = 4'd5;
        edge_t(t);
        div_load = 1'b0;
        chk("b2b_pend", div_pend, 1);
        tick_chk(6, "r8_finish", 1, 4'h0);
        chk("b2b_pend_clear", div_pend, 0);
        tick_chk(6, "r6a", 1, 4'h0);
        tick_chk(6, "r6b", 1, 4'h0);

        // flush at count 2 with coincident load (ratio 4 pending)
        edge_t(t);
        edge_t(t);
        data = 4'h3; flush = 1'b1; div_load = 1'b1; div_sel = 4'd3;
        edge_t(t);
        flush = 1'b0; div_load = 1'b0;
        chk("flush_tick_suppr", t, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_strobe", out_strobe, 0);
        chk("flush_pend_kept", div_pend, 1);
        tick_chk(6, "f1", 0, 0);
        chk("f1_pend_clear", div_pend, 0);
        tick_chk(4, "f2", 0, 0);
        chk("f2_out_valid", out_valid, 0);
        tick_chk(4, "f3", 1, 4'hF);
        chk("f3_out_valid", out_valid, 1);

        // async reset mid-period with a pending load
        div_load = 1'b1; div_sel = 4'd9;
        edge_t(t);
        div_load = 1'b0;
        chk("pre_rst_pend", div_pend, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_data", out_data, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_strobe", out_strobe, 0);
        chk("arst_div_pend", div_pend, 0);
        chk("arst_tick", tick, 0);
        @(posedge fast_clk);
        #1;
        rst = 1'b0;
        tick_chk(4, "post_rst_a", 0, 0);
        tick_chk(4, "post_rst_b", 0, 0);
        chk("post_rst_out_valid", out_valid, 0);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
